// File: rtl/mask_rev_digit_scanner.sv
// mask_rev_digit_scanner: presents the eight nibbles of the mask revision
// one at a time, most significant first, to a downstream seg7 decoder.
// Each digit dwells DWELL_CYCLES; the last BLANK_CYCLES of a dwell are blanked.
// The displayed word is snapshotted at frame start so a frame never tears.
// Optional feature macro: MASK_REV_LEADING_ZERO_SUPPRESS_EN (start each frame
// at the highest nonzero nibble instead of nibble 7).
module mask_rev_digit_scanner #(
  parameter int DWELL_CYCLES = 1000000,
  parameter int BLANK_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [31:0] mask_rev,
  input  logic        manual,
  input  logic [2:0]  sel,
  input  logic        hold,
  output logic [3:0]  digit,
  output logic [2:0]  digit_idx,
  output logic        blank,
  output logic        frame_done
);

  localparam int              CNT_W      = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL_CYCLES - 1);
  // With BLANK_CYCLES = 0 this equals DWELL_CYCLES, which the counter never reaches.
  localparam logic [31:0]     BLANK_FROM = 32'(DWELL_CYCLES - BLANK_CYCLES);

  logic [7:0][3:0]  r_snap;
  logic [2:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_frame_done;

  logic [7:0][3:0]  w_live;
  logic [2:0]       w_start_idx;
  logic             w_adv;
  logic             w_dwell_end;

  assign w_live      = mask_rev;
  assign w_adv       = ena & ~hold & ~manual;
  assign w_dwell_end = (r_cnt == CNT_LAST);

`ifdef MASK_REV_LEADING_ZERO_SUPPRESS_EN
  // Start index is the highest nonzero nibble of the live word (0 for all-zero).
  always_comb begin
    w_start_idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (w_live[i] != 4'd0) w_start_idx = 3'(i);
  end
`else
  assign w_start_idx = 3'd7;
`endif

  // Scan state: dwell counter, nibble index, frame snapshot and frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_idx        <= w_start_idx;
      r_snap       <= w_live;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_adv) begin
        if (w_dwell_end) begin
          r_cnt <= '0;
          if (r_idx == 3'd0) begin
            // Snapshot and start index come from the same sample of mask_rev.
            r_idx        <= w_start_idx;
            r_snap       <= w_live;
            r_frame_done <= 1'b1;
          end else begin
            r_idx <= r_idx - 3'd1;
          end
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // Output mux: manual mode shows the live word at sel, auto shows the snapshot.
  always_comb begin
    digit      = r_snap[r_idx];
    digit_idx  = r_idx;
    blank      = (32'(r_cnt) >= BLANK_FROM) | ~ena;
    frame_done = r_frame_done;
    if (manual) begin
      digit      = w_live[sel];
      digit_idx  = sel;
      blank      = 1'b0;
      frame_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_mask_rev_digit_scanner.sv
// Directed bench for mask_rev_digit_scanner with DWELL_CYCLES=4, BLANK_CYCLES=1.
// Inputs change and outputs are sampled on the falling edge.
module tb_mask_rev_digit_scanner;

  logic        clk = 1'b0;
  logic        rst, ena, manual, hold;
  logic [31:0] mask_rev;
  logic [2:0]  sel;
  logic [3:0]  digit;
  logic [2:0]  digit_idx;
  logic        blank, frame_done;

  int checks = 0;
  int errors = 0;

  mask_rev_digit_scanner #(.DWELL_CYCLES(4), .BLANK_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .ena(ena), .mask_rev(mask_rev), .manual(manual),
    .sel(sel), .hold(hold), .digit(digit), .digit_idx(digit_idx),
    .blank(blank), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] d, input logic [2:0] i,
                         input logic b, input logic f);
    chk({tag, ".digit"}, 32'(digit), 32'(d));
    chk({tag, ".idx"},   32'(digit_idx), 32'(i));
    chk({tag, ".blank"}, 32'(blank), 32'(b));
    chk({tag, ".fdone"}, 32'(frame_done), 32'(f));
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hand-written digit order for 32'h1234_ABCD, most significant first.
  logic [3:0] seq_a [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hA, 4'hB, 4'hC, 4'hD};
`ifdef MASK_REV_LEADING_ZERO_SUPPRESS_EN
  logic [3:0] seq_z [3] = '{4'hA, 4'h0, 4'h5};
`endif

  initial begin
    rst = 1'b1; ena = 1'b1; manual = 1'b0; hold = 1'b0; sel = 3'd0;
    mask_rev = 32'h1234_ABCD;
    tick(2);
    rst = 1'b0;
    // Reset state: idx 7, cnt 0, first digit shown, no pulse.
    chk_all("reset", 4'h1, 3'd7, 1'b0, 1'b0);

    // Two full frames: 4 cycles per digit, blank on the 4th, pulse opens frame 2.
    for (int f = 0; f < 2; f++)
      for (int d = 0; d < 8; d++)
        for (int c = 0; c < 4; c++) begin
          chk_all($sformatf("scan f%0d d%0d c%0d", f, d, c), seq_a[d], 3'(7 - d),
                  c == 3, (f == 1) && (d == 0) && (c == 0));
          tick(1);
        end
    chk("frame3_pulse", 32'(frame_done), 32'd1);

`ifndef MASK_REV_LEADING_ZERO_SUPPRESS_EN
    // Mid-frame change to zero: current frame keeps old digits, next shows zeros.
    tick(10);
    mask_rev = 32'h0;
    for (int k = 10; k < 32; k++) begin
      chk($sformatf("tear k%0d", k), 32'(digit), 32'(seq_a[k / 4]));
      tick(1);
    end
    for (int k = 0; k < 32; k++) begin
      if (k == 16) mask_rev = 32'h1234_ABCD;
      chk($sformatf("zero k%0d", k), 32'(digit), 32'h0);
      chk($sformatf("zero idx k%0d", k), 32'(digit_idx), 32'(7 - k / 4));
      tick(1);
    end
    chk("restore", 32'(digit), 32'h1);
`endif

    // Manual mode from idx 6, cnt 2. Nibble 3 of 1234ABCD is A, nibble 4 is 4.
    tick(6);
    chk_all("pre_manual", 4'h2, 3'd6, 1'b0, 1'b0);
    manual = 1'b1; sel = 3'd3;
    tick(1);
    chk_all("manual sel3", 4'hA, 3'd3, 1'b0, 1'b0);
    sel = 3'd4;
    tick(1);
    chk_all("manual sel4", 4'h4, 3'd4, 1'b0, 1'b0);
    mask_rev = 32'h0005_0000;
    #1 chk("manual live", 32'(digit), 32'h5);
    tick(3);
    mask_rev = 32'h1234_ABCD;
    manual = 1'b0;
    #1 chk_all("resume", 4'h2, 3'd6, 1'b0, 1'b0);
    tick(1);
    chk_all("resume+1", 4'h2, 3'd6, 1'b1, 1'b0);
    tick(1);
    chk_all("resume+2", 4'h3, 3'd5, 1'b0, 1'b0);

    // Hold for 10 cycles at idx 5, cnt 1.
    tick(1);
    hold = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk_all($sformatf("hold k%0d", k), 4'h3, 3'd5, 1'b0, 1'b0);
    end
    // Hold together with manual behaves as manual.
    manual = 1'b1; sel = 3'd0;
    tick(1);
    chk_all("hold+manual", 4'hD, 3'd0, 1'b0, 1'b0);
    manual = 1'b0; hold = 1'b0;
    tick(1);
    chk_all("hold_rel", 4'h3, 3'd5, 1'b0, 1'b0);   // cnt 2
    // Disabled: blank forced, no advance.
    ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk_all($sformatf("ena0 k%0d", k), 4'h3, 3'd5, 1'b1, 1'b0);
    end
    ena = 1'b1;
    #1 chk_all("ena1", 4'h3, 3'd5, 1'b0, 1'b0);
    tick(1);
    chk_all("ena1+1", 4'h3, 3'd5, 1'b1, 1'b0);
    tick(1);
    chk_all("ena1+2", 4'h4, 3'd4, 1'b0, 1'b0);

    // Reset at idx 2, cnt 2 with a new word: restart at idx 7, no pulse.
    tick(10);
    chk_all("pre_rst", 4'hB, 3'd2, 1'b0, 1'b0);
    rst = 1'b1; mask_rev = 32'h9876_5432;
    tick(1);
    rst = 1'b0;
    chk_all("post_rst", 4'h9, 3'd7, 1'b0, 1'b0);
    for (int k = 1; k < 32; k++) begin
      tick(1);
      chk($sformatf("no_pulse k%0d", k), 32'(frame_done), 32'd0);
    end
    tick(1);
    chk_all("rst_frame_end", 4'h9, 3'd7, 1'b0, 1'b1);

`ifdef MASK_REV_LEADING_ZERO_SUPPRESS_EN
    // Leading-zero suppression: 0A05 scans A,0,5 with a 12-cycle frame.
    rst = 1'b1; mask_rev = 32'h0000_0A05;
    tick(1);
    rst = 1'b0;
    for (int f = 0; f < 2; f++)
      for (int d = 0; d < 3; d++)
        for (int c = 0; c < 4; c++) begin
          chk_all($sformatf("lzs f%0d d%0d c%0d", f, d, c), seq_z[d], 3'(2 - d),
                  c == 3, (f == 1) && (d == 0) && (c == 0));
          tick(1);
        end
    mask_rev = 32'h0;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("lzs tail k%0d", k), 32'(digit), 32'(seq_z[k / 4]));
      tick(1);
    end
    // All-zero word: single digit 0, 4-cycle frames.
    for (int f = 0; f < 3; f++)
      for (int c = 0; c < 4; c++) begin
        chk_all($sformatf("lzs0 f%0d c%0d", f, c), 4'h0, 3'd0, c == 3, c == 0);
        tick(1);
      end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
